// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, transmitter state encoding, baud helpers.
// No logic of its own; constants and constant functions only.
// BRK/MARK states exist only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    ,
    ST_BRK    = 3'd5,
    ST_MARK   = 3'd6
`endif
  } tx_state_t;

  // Clocks per bit; integer division, remainder is simply dropped.
  function automatic int calc_bps_div(input longint clk_freq, input longint baud);
    return int'(clk_freq / baud);
  endfunction

  // Width of a counter that runs 0..div-1 (never narrower than one bit).
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time divider: counts DIV clocks while enabled and flags the last clock of each bit.
// Latency: bit_end is combinational from the count; DIV clocks between flags.
// No backpressure; clear forces the count back to zero (used while the line is idle).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running bit-time counter, wraps at the end of every bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

  assign bit_end = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter (start, DATA_BITS LSB first, optional parity, 1-2 stops); optional line break via UART_TX_BREAK_EN.
// Latency: line goes low the cycle after acceptance; tx_done pulses the cycle after the last stop bit ends.
// Backpressure: tx_ready only in IDLE or the final stop-bit clock; tx_valid is ignored otherwise.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD      = 1000000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  output logic                 tx_ready,
  output logic                 sci_tx,
  output logic                 tx_done,
  output logic                 tx_busy
);

  localparam int BPS_DIV = calc_bps_div(CLK_FREQ, BAUD);
  localparam int IDX_W   = $clog2(DATA_BITS + 1);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  // Illegal configurations stop elaboration outright.
  if (BPS_DIV < 2) begin : g_bad_div
    $fatal(1, "uart_tx_frame: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $fatal(1, "uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $fatal(1, "uart_tx_frame: PARITY must be 0..2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 bit_end;
  logic                 tick_clear;
  logic                 last_stop;
  logic                 brk_req;
  logic                 accept;

`ifdef UART_TX_BREAK_EN
  assign brk_req    = tx_break;
  assign tick_clear = (state == ST_IDLE) || (state == ST_BRK);
`else
  assign brk_req    = 1'b0;
  assign tick_clear = (state == ST_IDLE);
`endif

  uart_baud_tick #(.DIV(BPS_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clear   (tick_clear),
    .enable  (!tick_clear),
    .bit_end (bit_end)
  );

  // The final stop-bit clock doubles as an acceptance slot so frames can run gapless.
  assign last_stop = (state == ST_STOP) && bit_end && (stop_idx == STOP_LAST);
  assign tx_ready  = ((state == ST_IDLE) && !brk_req) || last_stop;
  assign accept    = tx_valid && tx_ready;
  assign tx_busy   = (state != ST_IDLE);

  // Frame sequencer; sci_tx is loaded with the level of the bit being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      sci_tx   <= 1'b1;
      tx_done  <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (accept) begin
        // Acceptance in STOP closes the previous frame in the same clock.
        tx_done  <= (state == ST_STOP);
        shreg    <= tx_data;
        par_bit  <= (PARITY == PARITY_ODD) ? ~(^tx_data) : (^tx_data);
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        state    <= ST_START;
        sci_tx   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
            if (tx_break) begin
              state  <= ST_BRK;
              sci_tx <= 1'b0;
            end
`endif
          end
          ST_START: begin
            if (bit_end) begin
              state   <= ST_DATA;
              sci_tx  <= shreg[0];
              bit_idx <= '0;
            end
          end
          ST_DATA: begin
            if (bit_end) begin
              if (bit_idx == IDX_LAST) begin
                if (PARITY != PARITY_NONE) begin
                  state  <= ST_PARITY;
                  sci_tx <= par_bit;
                end else begin
                  state    <= ST_STOP;
                  sci_tx   <= 1'b1;
                  stop_idx <= 1'b0;
                end
              end else begin
                shreg   <= shreg >> 1;
                sci_tx  <= shreg[1];
                bit_idx <= bit_idx + IDX_W'(1);
              end
            end
          end
          ST_PARITY: begin
            if (bit_end) begin
              state    <= ST_STOP;
              sci_tx   <= 1'b1;
              stop_idx <= 1'b0;
            end
          end
          ST_STOP: begin
            if (bit_end) begin
              if (stop_idx == STOP_LAST) begin
                tx_done <= 1'b1;
                state   <= ST_IDLE;
                sci_tx  <= 1'b1;
              end else begin
                stop_idx <= 1'b1;
              end
            end
          end
`ifdef UART_TX_BREAK_EN
          ST_BRK: begin
            // Hold the line low until break is released, then one bit of mark.
            if (!tx_break) begin
              state  <= ST_MARK;
              sci_tx <= 1'b1;
            end
          end
          ST_MARK: begin
            if (bit_end) begin
              state <= ST_IDLE;
            end
          end
`endif
          default: begin
            state  <= ST_IDLE;
            sci_tx <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter that generalises the team's fixed 8N1 byte transmitter. Data width, parity mode, stop-bit count and baud rate are set by parameters. Input uses a valid/ready handshake, and the word is latched at acceptance, so the source may change tx_data mid-frame. Sits between the packet/command logic and the board TX pin, and supports gapless back-to-back frames.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz
BAUD, 1000000, line bit rate in bit/s; BPS_DIV = CLK_FREQ/BAUD clocks per bit (integer division)
DATA_BITS, 8, payload bits per frame, legal 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous, active-low reset (sampled on rising clk edge, asserted when 0)
tx_valid  input  1  source has a word to send
tx_data  input  DATA_BITS  payload, sampled only on acceptance
tx_ready  output  1  block can accept a word this cycle
sci_tx  output  1  serial line, idle high, registered
tx_done  output  1  one-cycle pulse at end of each frame, registered
tx_busy  output  1  high while a frame is in progress

Behaviour:
- Elaboration checks: BPS_DIV >= 2, DATA_BITS in 5..9, PARITY in 0..2, STOP_BITS in 1..2. Any violation is a fatal elaboration error.
- Bit counter width is clog2(BPS_DIV). Data-bit index width is clog2(DATA_BITS+1).
- States: IDLE, START, DATA, PARITY, STOP. Every non-IDLE state lasts BPS_DIV clocks per bit. "bit_end" means the bit counter equals BPS_DIV-1.
- Reset (rst == 0 at an edge):
  - Outputs: sci_tx = 1, tx_done = 0, tx_busy = 0.
  - State goes to IDLE; counters and shift register are cleared.
  - A frame in progress is abandoned with no done pulse. The line is high on the next cycle.
- tx_ready (combinational) is high when:
  - state == IDLE, or
  - state == STOP at bit_end of the last stop bit.
- Acceptance is tx_valid && tx_ready at a rising edge:
  - tx_data is latched into the shift register.
  - The parity bit is computed at the same time: odd = ~^tx_data, even = ^tx_data.
  - The state goes to START, and sci_tx = 0 from the next cycle.
- Transitions:
  - START --bit_end--> DATA.
  - DATA shifts out DATA_BITS bits. After the last bit, at bit_end, go to PARITY if PARITY != 0, otherwise STOP.
  - PARITY --bit_end--> STOP.
  - STOP runs STOP_BITS bit-times with sci_tx = 1. At the final bit_end, go to START if a word is accepted in that cycle, otherwise IDLE.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * BPS_DIV clocks, counted from the first low cycle.
- tx_done is high for exactly one cycle, the cycle after the final stop-bit bit_end.
- Back-to-back frames: acceptance during the final stop-bit cycle gives zero idle cycles between frames. tx_done still pulses once per frame.
- tx_busy = (state != IDLE).
- tx_valid is ignored while tx_ready = 0. Dropping tx_valid mid-frame has no effect on the frame.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - Adds input tx_break (1 bit).
  - In IDLE with tx_break = 1, tx_ready = 0 (break wins over a simultaneous tx_valid) and the FSM enters BRK.
  - In BRK, sci_tx = 0 for as long as tx_break is high.
  - When tx_break falls, the FSM enters MARK: sci_tx = 1 for one bit time (BPS_DIV clocks), then IDLE.
  - tx_break raised mid-frame is ignored until the frame ends.
  - tx_busy is high in BRK and MARK. tx_done never pulses for a break.
- Not defined: no tx_break port, no BRK/MARK states; behaviour is exactly as above.

Decomposition:
- Package uart_pkg holds:
  - parity constants PARITY_NONE/ODD/EVEN = 0/1/2;
  - the state encoding;
  - a constant function computing BPS_DIV and the counter width.
- One sub-module, uart_baud_tick (parameter DIV):
  - inputs: clk, rst, clear, enable;
  - output: bit_end.
  - It is shared with the future receiver.

Test Plan:
1. Defaults (BPS_DIV = 25), send 0xA5 -> sci_tx low from the cycle after acceptance; bits 0,1,0,1,0,0,1,0,1,1 for 25 clocks each; tx_done pulse 250 clocks after the first low cycle; tx_ready low throughout the frame except its last cycle.
2. PARITY = 2, send 0x07 -> parity bit 1 and 11-bit frame (275 clocks). Repeat with PARITY = 1 -> parity bit 0.
3. tx_valid held high with 0x55 then 0xAA -> second start bit immediately follows the stop bit, zero idle clocks, two tx_done pulses 250 clocks apart.
4. DATA_BITS = 7, STOP_BITS = 2, send 0x41 -> 10-bit frame of 250 clocks, line high during clocks 200..249; tx_data changed mid-frame does not alter the output.
5. rst driven low during data bit 3 -> next cycle sci_tx = 1, tx_busy = 0, tx_ready = 1, no tx_done. The next word transmits correctly.
6. UART_TX_BREAK_EN defined, tx_break high for 100 clocks while tx_valid = 1 -> sci_tx low for 100 clocks, then high for 25, no acceptance during break; the queued word is accepted on the first IDLE cycle.
